// File: rtl/usb_bulk_in_fifo.sv
// ----------------------------------------------------------------------------
// usb_bulk_in_fifo
//
// Packet-aware byte FIFO feeding the USB transaction layer's bulk-IN source.
// User logic streams bytes in on an AXI4-Stream style slave port. The stream
// is cut into USB packets of at most MAX_PACKET bytes: a cut happens on the
// user's s_tlast or on every MAX_PACKET-th byte, whichever comes first.
// Bytes only become visible to the read side once their packet is committed,
// so has_data_o never promises an IN DATA phase that cannot be completed.
//
// Optional feature (compile-time macro USB_BULK_IN_TIMEOUT_EN):
//   a partial packet that sees TIMEOUT idle cycles is committed as-is.
//   Without the macro, partial packets wait for s_tlast or the auto-split.
//
// Parameters
//   ADDR_WIDTH  log2 of FIFO depth in bytes
//   MAX_PACKET  maximum USB packet size in bytes (power of two, <= depth/2)
//   TIMEOUT     idle cycles before a partial packet is committed (optional)
//
// Ports
//   clock        single clock (USB/ULPI 60 MHz)
//   rst_n        asynchronous active-low reset
//   flush_i      synchronous clear of contents and pointers
//   s_tvalid/s_tready/s_tlast/s_tdata   user write side
//   has_data_o   at least one committed packet stored
//   m_tvalid/m_tready/m_tlast/m_tdata   read side toward the transaction layer
//   level_o      bytes stored (committed + uncommitted), prefetched byte excluded
//   pkt_count_o  committed packets not yet fully consumed
// ----------------------------------------------------------------------------
module usb_bulk_in_fifo #(
   parameter int ADDR_WIDTH = 11,
   parameter int MAX_PACKET = 512,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   input  logic [7:0]            s_tdata,
   output logic                  has_data_o,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic [7:0]            m_tdata,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic [ADDR_WIDTH:0]   pkt_count_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int SEG_W = (MAX_PACKET > 1) ? $clog2(MAX_PACKET) : 1;

   // Elaboration-time parameter sanity.
   if ((MAX_PACKET < 1) || ((MAX_PACKET & (MAX_PACKET - 1)) != 0)) begin : g_bad_max_packet
      $error("usb_bulk_in_fifo: MAX_PACKET must be a power of two");
   end
   if (MAX_PACKET > (DEPTH / 2)) begin : g_bad_depth
      $error("usb_bulk_in_fifo: MAX_PACKET must not exceed half the FIFO depth");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("usb_bulk_in_fifo: TIMEOUT must be at least 1");
   end

   // One prefetched output beat.
   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } beat_t;

   // ------------------------------------------------------------------------
   // Storage: data RAM plus a separate last-flag array. The flag array has
   // its own write port so a timeout can mark an already written byte.
   // ------------------------------------------------------------------------
   logic [7:0] data_ram [DEPTH];
   logic       last_ram [DEPTH];

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   cmt_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [SEG_W-1:0]      seg_cnt;
   logic                  rdy_en;
   beat_t                 out_q;

   logic                  full;
   logic                  wr_fire;
   logic                  wr_last;
   logic                  wr_commit;
   logic                  to_commit;
   logic                  commit;
   logic                  pop;
   logic                  rd_en;

   logic                  last_we;
   logic [ADDR_WIDTH-1:0] last_waddr;
   logic                  last_wval;

   // Same address bits, opposite wrap bit: exactly DEPTH bytes in flight.
   assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_WIDTH{1'b0}}};

   // rdy_en keeps s_tready low through reset; flush_i blocks the handshake
   // so no byte is acknowledged and then silently dropped.
   assign s_tready  = rdy_en && !full && !flush_i;
   assign wr_fire   = s_tvalid && s_tready;

   // Auto-split: the MAX_PACKET-th byte of a segment always closes it, which
   // also absorbs a user tlast on that byte (no zero-length packet follows).
   assign wr_last   = s_tlast || (seg_cnt == SEG_W'(MAX_PACKET - 1));
   assign wr_commit = wr_fire && wr_last;
   assign commit    = wr_commit || to_commit;

   assign pop       = m_tvalid && m_tready && m_tlast;

   // Refill the output register whenever it is empty or being drained, but
   // only from the committed region.
   assign rd_en     = !flush_i && (rd_ptr != cmt_ptr) && (!m_tvalid || m_tready);

   assign m_tdata   = out_q.data;
   assign m_tlast   = out_q.last;

   // ------------------------------------------------------------------------
   // Idle timeout (optional)
   // ------------------------------------------------------------------------
`ifdef USB_BULK_IN_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0] idle_cnt;

   // A write in the same cycle wins: it restarts the idle window instead.
   assign to_commit = !flush_i && !wr_fire && (seg_cnt != '0) &&
                      (idle_cnt == IDLE_W'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (flush_i || wr_fire || to_commit || (seg_cnt == '0)) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign to_commit = 1'b0;
`endif

   // Last-flag write port: normal writes store the computed flag, a timeout
   // retro-marks the most recently written byte. Both never coincide.
   always_comb begin
      last_we    = wr_fire;
      last_waddr = wr_ptr[ADDR_WIDTH-1:0];
      last_wval  = wr_last;
`ifdef USB_BULK_IN_TIMEOUT_EN
      if (to_commit) begin
         last_we    = 1'b1;
         last_waddr = wr_ptr[ADDR_WIDTH-1:0] - 1'b1;
         last_wval  = 1'b1;
      end
`endif
   end

   // ------------------------------------------------------------------------
   // Memories (no reset)
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (wr_fire) begin
         data_ram[wr_ptr[ADDR_WIDTH-1:0]] <= s_tdata;
      end
   end

   always_ff @(posedge clock) begin
      if (last_we) begin
         last_ram[last_waddr] <= last_wval;
      end
   end

   // ------------------------------------------------------------------------
   // Write-side readiness after reset release
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Pointers, segment counter, packet count, status
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         cmt_ptr     <= '0;
         rd_ptr      <= '0;
         seg_cnt     <= '0;
         pkt_count_o <= '0;
         has_data_o  <= 1'b0;
         level_o     <= '0;
      end else if (flush_i) begin
         wr_ptr      <= '0;
         cmt_ptr     <= '0;
         rd_ptr      <= '0;
         seg_cnt     <= '0;
         pkt_count_o <= '0;
         has_data_o  <= 1'b0;
         level_o     <= '0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         if (wr_commit) begin
            cmt_ptr <= wr_ptr + 1'b1;
         end else if (to_commit) begin
            cmt_ptr <= wr_ptr;
         end

         if (wr_fire) begin
            seg_cnt <= wr_last ? '0 : seg_cnt + 1'b1;
         end else if (to_commit) begin
            seg_cnt <= '0;
         end

         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         case ({commit, pop})
            2'b10:   pkt_count_o <= pkt_count_o + 1'b1;
            2'b01:   pkt_count_o <= pkt_count_o - 1'b1;
            default: pkt_count_o <= pkt_count_o;
         endcase

         // Both trail their source by one cycle on purpose: has_data_o
         // rises together with m_tvalid for a freshly committed packet.
         has_data_o <= (pkt_count_o != '0);
         level_o    <= wr_ptr - rd_ptr;
      end
   end

   // ------------------------------------------------------------------------
   // Output register: the synchronous RAM read lands directly here, so it
   // doubles as the first-word-fall-through prefetch stage.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= '0;
         m_tvalid <= 1'b0;
      end else if (flush_i) begin
         out_q    <= '0;
         m_tvalid <= 1'b0;
      end else if (rd_en) begin
         out_q    <= '{last: last_ram[rd_ptr[ADDR_WIDTH-1:0]],
                       data: data_ram[rd_ptr[ADDR_WIDTH-1:0]]};
         m_tvalid <= 1'b1;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_usb_bulk_in_fifo.sv
// ----------------------------------------------------------------------------
// tb_usb_bulk_in_fifo
//
// Self-checking bench for usb_bulk_in_fifo. A packet-level reference model
// collects accepted bytes into a pending packet, and moves the packet into
// an expected-beat list when it is closed (user tlast, MAX_PACKET bytes, or
// an idle timeout). A monitor consumes read-side beats against that list.
// ----------------------------------------------------------------------------
module tb_usb_bulk_in_fifo;

   localparam int AW   = 11;
   localparam int MAXP = 512;
   localparam int TO   = 16;
   localparam int EXPN = 32768;

   logic          clock = 1'b0;
   logic          rst_n;
   logic          flush_i;
   logic          s_tvalid;
   logic          s_tready;
   logic          s_tlast;
   logic [7:0]    s_tdata;
   logic          has_data_o;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;
   logic [7:0]    m_tdata;
   logic [AW:0]   level_o;
   logic [AW:0]   pkt_count_o;

   usb_bulk_in_fifo #(
      .ADDR_WIDTH (AW),
      .MAX_PACKET (MAXP),
      .TIMEOUT    (TO)
   ) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tlast     (s_tlast),
      .s_tdata     (s_tdata),
      .has_data_o  (has_data_o),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tlast     (m_tlast),
      .m_tdata     (m_tdata),
      .level_o     (level_o),
      .pkt_count_o (pkt_count_o)
   );

   always #8 clock = ~clock;

   // Reference model state
   logic [7:0] exp_d [EXPN];
   logic       exp_l [EXPN];
   logic [7:0] cur_d [MAXP];
   int         wr_n;         // expected beats released (committed)
   int         rd_n;         // beats consumed by the monitor
   int         n_cur;        // bytes in the pending (uncommitted) packet
   int         n_pkts_cmt;
   int         n_pkts_rd;
   int         n_chk;
   int         n_fail;
   int         rdy_mode;     // 2: random m_tready driven by background loop
   logic       stall_armed;
   logic [7:0] held_d;
   logic       held_l;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   // Close the pending packet: its bytes become readable, last on the final.
   task automatic model_commit();
      for (int i = 0; i < n_cur; i++) begin
         exp_d[wr_n] = cur_d[i];
         exp_l[wr_n] = (i == n_cur - 1);
         wr_n++;
      end
      n_pkts_cmt++;
      n_cur = 0;
   endtask

   task automatic model_accept(input logic [7:0] d, input logic l);
      cur_d[n_cur] = d;
      n_cur++;
      if (l || (n_cur == MAXP)) model_commit();
   endtask

   // Quiescent expectations: the prefetch register holds one committed byte
   // whenever any committed byte is still unread.
   task automatic chk_quiet(input string tag);
      int pend;
      int lvl;
      sample();
      pend = wr_n - rd_n;
      lvl  = n_cur + pend - ((pend > 0) ? 1 : 0);
      chk({tag, "_pkt"},   32'(pkt_count_o), 32'(n_pkts_cmt - n_pkts_rd));
      chk({tag, "_level"}, 32'(level_o),     32'(lvl));
      chk({tag, "_hd"},    32'(has_data_o),  32'((n_pkts_cmt - n_pkts_rd) != 0));
      tick(1);
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      int waited;
      waited   = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      sample();
      while (!s_tready && waited < 5000) begin
         tick(1);
         sample();
         waited++;
      end
      if (s_tready) model_accept(d, l);
      else chk("wr_stall", 32'(s_tready), 32'd1);
      @(posedge clock);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic try_push(input logic [7:0] d, input logic l, output logic ok);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      sample();
      ok = s_tready;
      if (ok) model_accept(d, l);
      @(posedge clock);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int c;
      c        = 0;
      rdy_mode = 0;
      m_tready = 1'b1;
      sample();
      while (rd_n != wr_n && c < max_cyc) begin
         tick(1);
         sample();
         c++;
      end
      if (rd_n != wr_n) chk("drain_timeout", 32'(rd_n), 32'(wr_n));
      tick(3);
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      tick(1);
      flush_i = 1'b0;
      n_cur   = 0;
      tick(2);
   endtask

   // Read-side scoreboard and stall-stability monitor.
   task automatic monitor_loop();
      forever begin
         @(negedge clock);
         if (rst_n && !flush_i) begin
            if (stall_armed && m_tvalid) begin
               chk("stall_data", 32'(m_tdata), 32'(held_d));
               chk("stall_last", 32'(m_tlast), 32'(held_l));
            end
            stall_armed = m_tvalid && !m_tready;
            held_d      = m_tdata;
            held_l      = m_tlast;
            if (m_tvalid && m_tready) begin
               if (rd_n >= wr_n) begin
                  chk("rd_extra_beat", 32'(m_tvalid), 32'd0);
               end else begin
                  chk("rd_data", 32'(m_tdata), 32'(exp_d[rd_n]));
                  chk("rd_last", 32'(m_tlast), 32'(exp_l[rd_n]));
                  if (exp_l[rd_n]) n_pkts_rd++;
                  rd_n++;
               end
            end
         end else begin
            stall_armed = 1'b0;
         end
      end
   endtask

   task automatic rdy_loop();
      forever begin
         @(posedge clock);
         #1;
         if (rdy_mode == 2) m_tready = ($urandom_range(3, 0) != 0);
      end
   endtask

   initial begin
      logic ok;
      logic found;
      int   cnt;
      int   rd0;

      rst_n = 1'b0; flush_i = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
      s_tdata = 8'h00; m_tready = 1'b0;
      wr_n = 0; rd_n = 0; n_cur = 0; n_pkts_cmt = 0; n_pkts_rd = 0;
      n_chk = 0; n_fail = 0; rdy_mode = 0;
      stall_armed = 1'b0; held_d = 8'h00; held_l = 1'b0;

      fork
         monitor_loop();
         rdy_loop();
      join_none

      // ---- reset state ----
      repeat (3) @(negedge clock);
      chk("rst_tready", 32'(s_tready),    32'd0);
      chk("rst_tvalid", 32'(m_tvalid),    32'd0);
      chk("rst_tlast",  32'(m_tlast),     32'd0);
      chk("rst_tdata",  32'(m_tdata),     32'd0);
      chk("rst_level",  32'(level_o),     32'd0);
      chk("rst_pkt",    32'(pkt_count_o), 32'd0);
      chk("rst_hd",     32'(has_data_o),  32'd0);
      rst_n = 1'b1;
      tick(1);
      sample();
      chk("rel_tready", 32'(s_tready), 32'd1);
      tick(1);

      // ---- 5-byte packet, has_data latency ----
      for (int i = 1; i <= 5; i++) push(8'(i), i == 5);
      sample();
      chk("t1_pkt_c1", 32'(pkt_count_o), 32'd1);
      chk("t1_hd_c1",  32'(has_data_o),  32'd0);
      tick(1);
      sample();
      chk("t1_hd_c2",    32'(has_data_o), 32'd1);
      chk("t1_valid_c2", 32'(m_tvalid),   32'd1);
      chk("t1_data_c2",  32'(m_tdata),    32'h01);
      tick(3);
      chk_quiet("t1_held");
      drain(100);
      chk_quiet("t1_done");

      // ---- 1300-byte stream, auto-split 512/512/276 ----
      m_tready = 1'b0;
      rd0 = n_pkts_rd;
      for (int i = 0; i < 1300; i++) push(8'($urandom), i == 1299);
      tick(3);
      sample();
      chk("t2_peak", 32'(pkt_count_o), 32'd3);
      tick(1);
      chk_quiet("t2_held");
      drain(3000);
      chk("t2_npkts", 32'(n_pkts_rd - rd0), 32'd3);
      chk_quiet("t2_done");

      // ---- fill with reads stalled ----
      m_tready = 1'b0;
      cnt = 0;
      ok  = 1'b1;
      while (ok && cnt < 2100) begin
         try_push(8'($urandom), cnt == 2048, ok);
         if (ok) cnt++;
      end
      chk("t3_accepted", 32'(cnt), 32'd2049);
      tick(2);
      sample();
      chk("t3_full_tready", 32'(s_tready), 32'd0);
      chk("t3_full_level",  32'(level_o),  32'd2048);
      tick(1);
      chk_quiet("t3_full");
      m_tready = 1'b1;
      sample();
      tick(1);
      m_tready = 1'b0;
      sample();
      chk("t3_one_beat_tready", 32'(s_tready), 32'd1);
      tick(1);
      drain(5000);
      chk_quiet("t3_done");

      // ---- flush discards a partial packet ----
      push(8'hA1, 1'b0);
      push(8'hA2, 1'b0);
      do_flush();
      chk_quiet("fl_done");
      for (int i = 0; i < 3; i++) push(8'(8'hB0 + i), i == 2);
      drain(100);
      chk_quiet("fl_after");

      // ---- commit coinciding with final beat of another packet ----
      m_tready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'hC0 + i), i == 3);
      push(8'hD0, 1'b0);
      push(8'hD1, 1'b0);
      tick(3);
      m_tready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         sample();
         if (m_tvalid && m_tlast) found = 1'b1;
         else tick(1);
      end
      chk("t4_found_last", 32'(found), 32'd1);
      if (found) begin
         s_tvalid = 1'b1;
         s_tdata  = 8'hD2;
         s_tlast  = 1'b1;
         chk("t4_tready", 32'(s_tready), 32'd1);
         if (s_tready) model_accept(8'hD2, 1'b1);
         @(posedge clock);
         #1;
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
         m_tready = 1'b0;
         sample();
         chk("t4_pkt_same", 32'(pkt_count_o), 32'd1);
         chk("t4_hd_same",  32'(has_data_o),  32'd1);
         tick(1);
         sample();
         chk("t4_hd_next",  32'(has_data_o),  32'd1);
         tick(1);
      end
      drain(100);
      chk_quiet("t4_done");

      // ---- random back-pressure, 10+ wraps of 300-byte packets ----
      rdy_mode = 2;
      for (int p = 0; p < 69; p++) begin
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7, 0) == 0) tick(1);
            push(8'($urandom), i == 299);
         end
      end
      drain(10000);
      chk_quiet("t5_done");

      // ---- idle timeout on a partial packet ----
      m_tready = 1'b1;
      push(8'hE1, 1'b0);
      push(8'hE2, 1'b0);
      push(8'hE3, 1'b0);
`ifdef USB_BULK_IN_TIMEOUT_EN
      model_commit();
      tick(15);
      sample();
      chk("t6_pkt_before", 32'(pkt_count_o), 32'd0);
      tick(1);
      sample();
      chk("t6_pkt_commit", 32'(pkt_count_o), 32'd1);
      tick(1);
      drain(100);
      chk_quiet("t6_done");
`else
      tick(40);
      sample();
      chk("t6_hd_idle",    32'(has_data_o),  32'd0);
      chk("t6_pkt_idle",   32'(pkt_count_o), 32'd0);
      chk("t6_valid_idle", 32'(m_tvalid),    32'd0);
      tick(1);
      chk_quiet("t6_held");
      do_flush();
      chk_quiet("t6_done");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_bulk_in_fifo.md
Name: usb_bulk_in_fifo

Overview:
- Packet-aware byte FIFO directly upstream of the USB transaction layer's bulk-IN source port (bid_has_data_i / bid_tvalid_i / bid_tready_o / bid_tlast_i / bid_tdata_i).
- Accepts an arbitrary-length AXI4-Stream from user logic and splits it into USB packets of at most MAX_PACKET bytes.
- Advertises has_data only once at least one complete packet is stored, so the transaction layer never starts an IN DATA phase it cannot finish.

Parameters:
- ADDR_WIDTH, 11, log2 of FIFO depth in bytes (depth = 2048).
- MAX_PACKET, 512, maximum bulk packet size in bytes (512 HS, 64 FS). Must be a power of two. Must be <= 2**(ADDR_WIDTH-1).
- TIMEOUT, 1024, idle cycles before a partial packet is committed (used only with the optional feature).

Ports:
- clock  in  1  USB/ULPI 60 MHz clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all contents and pointers.
- s_tvalid  in  1  user write-side valid.
- s_tready  out  1  user write-side ready.
- s_tlast  in  1  user end-of-packet marker.
- s_tdata  in  8  user write data.
- has_data_o  out  1  at least one committed packet is stored; drives bid_has_data_i.
- m_tvalid  out  1  read-side valid; drives bid_tvalid_i.
- m_tready  in  1  read-side ready; from bid_tready_o.
- m_tlast  out  1  last byte of the current packet; drives bid_tlast_i.
- m_tdata  out  8  read-side data; drives bid_tdata_i.
- level_o  out  ADDR_WIDTH+1  bytes stored, committed plus uncommitted.
- pkt_count_o  out  ADDR_WIDTH+1  number of committed packets.

Behaviour:
- Clock and reset: single clock domain, clock; reset rst_n is asynchronous, active-low.
- Reset values, applied on rst_n low or flush_i high:
  - all pointers 0; pkt_count_o 0; level_o 0.
  - has_data_o 0; m_tvalid 0; m_tlast 0; m_tdata 8'h00.
  - s_tready 0 while rst_n is low, 1 on the first cycle after release.
- Storage:
  - 2**ADDR_WIDTH x 8 data RAM with synchronous read.
  - Separate 2**ADDR_WIDTH x 1 last-flag array that can be written independently of the data RAM.
- Pointers (all ADDR_WIDTH+1 bits, MSB used for wrap detection):
  - wr_ptr: next byte to write.
  - cmt_ptr: one past the last committed byte.
  - rd_ptr: next byte to read.
- Full and empty:
  - full = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_WIDTH{1'b0}}}; s_tready = !full.
  - Readable region is rd_ptr up to cmt_ptr; uncommitted bytes are never presented.
- Write, on s_tvalid && s_tready:
  - Store data and last flag = s_tlast || (seg_cnt == MAX_PACKET-1); wr_ptr += 1.
  - If last flag is set: cmt_ptr <= wr_ptr+1, seg_cnt <= 0, packet committed. Otherwise seg_cnt += 1.
- Auto-split: the stream is cut every MAX_PACKET bytes. A user tlast exactly on byte MAX_PACKET produces one packet; no zero-length packet is generated. Because MAX_PACKET <= half the depth, a partial packet alone can never fill the FIFO (no deadlock).
- Read path:
  - One-entry prefetch output register, first-word-fall-through.
  - Issue a RAM read when (!m_tvalid || (m_tvalid && m_tready)) && rd_ptr != cmt_ptr. The RAM read is registered; m_tvalid rises 2 cycles after the first committed byte's write cycle.
  - Sustained throughput: 1 byte/clock with m_tready held high.
  - m_tdata and m_tlast hold stable while m_tvalid && !m_tready.
- Packet count:
  - +1 on commit; -1 on m_tvalid && m_tready && m_tlast; simultaneous commit and consume leaves it unchanged.
  - has_data_o = pkt_count_o != 0, registered.
- level_o = wr_ptr - rd_ptr (modular), updated one cycle after each transfer. Bytes held in the prefetch register count as read.
- flush_i during an active read:
  - m_tvalid drops next cycle and the partial packet is discarded.
  - The downstream module must only flush outside an IN transaction.
- Pointer wrap: pointers wrap modulo 2**(ADDR_WIDTH+1) with no bubble.

Optional Feature:
- Macro: USB_BULK_IN_TIMEOUT_EN.
- With the macro defined:
  - An idle counter runs while seg_cnt != 0 and no write occurs; it is cleared on any write, commit or flush.
  - When the counter reaches TIMEOUT-1, set the last flag at address wr_ptr-1, set cmt_ptr <= wr_ptr, seg_cnt <= 0, and count one packet.
  - If a write hits the same cycle as the timeout, the write takes priority and the counter resets.
- Without the macro: partial packets wait indefinitely for s_tlast or auto-split; the TIMEOUT parameter is unused.

Test Plan:
- Write 5 bytes 01..05 with tlast on 05 -> has_data_o=1 two cycles later; read gives 01..05, m_tlast only on 05; pkt_count_o returns to 0 and has_data_o drops.
- Write a 1300-byte stream with a single tlast, MAX_PACKET=512 -> packets of 512, 512 and 276 bytes; m_tlast on bytes 512, 1024 and 1300; pkt_count_o peaks at 3.
- Fill with m_tready=0 and 2048 bytes in 512-byte packets -> s_tready=0 at level_o=2048; one read beat restores s_tready=1.
- Commit a packet on the same cycle as the final beat of another packet is consumed -> pkt_count_o unchanged; has_data_o stays 1.
- Random m_tready back-pressure plus 10 full wrap-arounds of 300-byte packets -> byte-exact scoreboard match, m_tdata stable while stalled.
- With USB_BULK_IN_TIMEOUT_EN and TIMEOUT=16, write 3 bytes without tlast and then idle -> commit after 16 idle cycles; read gives 3 bytes with m_tlast on the third. Without the macro, has_data_o stays 0.
